// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: default sizes, FSM state
// encoding, instruction field positions and field extraction helpers.
package alu_issue_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned NREG_DEF  = 4;
    localparam int unsigned INSTR_W   = 12;
    localparam int unsigned REG_AW    = 2;

    // instr layout: [11:9] opc, [8:7] dst, [6:5] srcA, [4:3] srcB, [2] cin, [1] we, [0] reserved
    localparam int unsigned OPC_LSB  = 9;
    localparam int unsigned DST_LSB  = 7;
    localparam int unsigned SRCA_LSB = 5;
    localparam int unsigned SRCB_LSB = 3;
    localparam int unsigned CIN_BIT  = 2;
    localparam int unsigned WE_BIT   = 1;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [REG_AW-1:0]  reg_addr_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StWb    = 2'd3
    } state_e;

    function automatic logic [2:0] instr_opc(instr_t i);
        return i[OPC_LSB +: 3];
    endfunction

    function automatic reg_addr_t instr_dst(instr_t i);
        return i[DST_LSB +: REG_AW];
    endfunction

    function automatic reg_addr_t instr_srca(instr_t i);
        return i[SRCA_LSB +: REG_AW];
    endfunction

    function automatic reg_addr_t instr_srcb(instr_t i);
        return i[SRCB_LSB +: REG_AW];
    endfunction

    function automatic logic instr_cin(instr_t i);
        return i[CIN_BIT];
    endfunction

    function automatic logic instr_we(instr_t i);
        return i[WE_BIT];
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus between the issue controller and its environment: request/preload
// inputs, ALU operand/result bundle and status/result outputs.
// master: requester + ALU side; slave: alu_issue_ctrl.
interface alu_issue_ctrl_if
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic             start;
    instr_t           instr;
    logic             ld_en;
    reg_addr_t        ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_c;
    logic [2:0]       alu_opc;
    logic [WIDTH-1:0] alu_w;
    logic             alu_zer;
    logic             alu_neg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             nf;

    modport master (
        output start, instr, ld_en, ld_addr, ld_data, alu_w, alu_zer, alu_neg,
        input  alu_a, alu_b, alu_c, alu_opc, busy, done, result, zf, nf
    );

    modport slave (
        input  start, instr, ld_en, ld_addr, ld_data, alu_w, alu_zer, alu_neg,
        output alu_a, alu_b, alu_c, alu_opc, busy, done, result, zf, nf
    );

endinterface

// File: rtl/alu_regfile.sv
// General register file: NREG x WIDTH, two combinational read ports, one
// synchronous write port, synchronous active-low clear of all entries.
// Ports: clk, rst_n, we_i/waddr_i/wdata_i (write), raddr_*_i/rdata_*_o (reads).
module alu_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREG  = NREG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  reg_addr_t        waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  reg_addr_t        raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  reg_addr_t        raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);
    logic [WIDTH-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external ALU. Runs a fixed IDLE->FETCH->EXEC->WB
// cycle per instruction: latch instr, latch operands from the regfile, capture
// the ALU result/flags, then optionally write the result back.
// Ports: clk, rst_n (sync, active-low), bus (alu_issue_ctrl_if.slave).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREG  = NREG_DEF
) (
    input logic            clk,
    input logic            rst_n,
    alu_issue_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    instr_t           instr_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       opc_q;
    logic             c_q, zf_q, nf_q;

    logic             rf_we;
    reg_addr_t        rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rd_a, rd_b;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (instr_srca(instr_q)),
        .rdata_a_o (rd_a),
        .raddr_b_i (instr_srcb(instr_q)),
        .rdata_b_o (rd_b)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StFetch;
            StFetch: state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load and write-back never compete: loads are only honoured in IDLE.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = bus.ld_addr;
        rf_wdata = bus.ld_data;
        if (state_q == StWb) begin
            rf_we    = instr_we(instr_q);
            rf_waddr = instr_dst(instr_q);
            rf_wdata = result_q;
        end else if (state_q == StIdle) begin
            rf_we    = bus.ld_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opc_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.start) begin
                instr_q <= bus.instr;
            end
            // opc/cin are registered alongside the operands so the ALU sees a
            // consistent set in EXEC and keeps it through IDLE.
            if (state_q == StFetch) begin
                a_q   <= rd_a;
                b_q   <= rd_b;
                opc_q <= instr_opc(instr_q);
                c_q   <= instr_cin(instr_q);
            end
            if (state_q == StExec) begin
                result_q <= bus.alu_w;
                zf_q     <= bus.alu_zer;
                nf_q     <= bus.alu_neg;
            end
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StWb);
    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.alu_c   = c_q;
    assign bus.alu_opc = opc_q;
    assign bus.result  = result_q;
    assign bus.zf      = zf_q;
    assign bus.nf      = nf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] ref_rf [4];

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(16)) bus ();

    alu_issue_ctrl #(.WIDTH(16), .NREG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU attached to the bus; also serves as the reference ALU.
    function automatic logic [15:0] alu_ref(input logic [2:0] opc, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        case (opc)
            3'd0:    return 16'd0 - a;
            3'd1:    return a + 16'd1;
            3'd2:    return a + b + {15'd0, c};
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return 16'd0;
        endcase
    endfunction

    assign bus.alu_w   = alu_ref(bus.alu_opc, bus.alu_a, bus.alu_b, bus.alu_c);
    assign bus.alu_zer = (bus.alu_w == 16'd0);
    assign bus.alu_neg = bus.alu_w[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction (optionally with a same-cycle preload) and checks
    // every phase against the reference register model.
    task automatic issue(input logic [2:0] opc, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic cin, input logic we,
                         input logic ld, input logic [1:0] la, input logic [15:0] ldd);
        logic [11:0] ins;
        logic [15:0] exp;
        ins = {opc, dst, sa, sb, cin, we, 1'b0};
        ins[0] = 1'($urandom_range(0, 1));
        bus.instr = ins; bus.start = 1'b1;
        bus.ld_en = ld; bus.ld_addr = la; bus.ld_data = ldd;
        tick();
        bus.start = 1'b0; bus.ld_en = 1'b0; bus.instr = 12'($urandom);
        bus.ld_data = 16'($urandom);
        if (ld) ref_rf[la] = ldd;
        exp = alu_ref(opc, ref_rf[sa], ref_rf[sb], cin);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL fetch_status: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.alu_a !== ref_rf[sa]) begin
            errors++; $display("FAIL exec_alu_a: got %h want %h", bus.alu_a, ref_rf[sa]);
        end
        checks++;
        if (bus.alu_b !== ref_rf[sb]) begin
            errors++; $display("FAIL exec_alu_b: got %h want %h", bus.alu_b, ref_rf[sb]);
        end
        checks++;
        if (bus.alu_opc !== opc || bus.alu_c !== cin || bus.done !== 1'b0) begin
            errors++; $display("FAIL exec_ctrl: opc=%0d c=%b done=%b want %0d %b 0",
                               bus.alu_opc, bus.alu_c, bus.done, opc, cin);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL wb_done: done=%b busy=%b want 1 1", bus.done, bus.busy);
        end
        checks++;
        if (bus.result !== exp) begin
            errors++; $display("FAIL wb_result: got %h want %h", bus.result, exp);
        end
        checks++;
        if ({bus.zf, bus.nf} !== {exp == 16'd0, exp[15]}) begin
            errors++; $display("FAIL wb_flags: zf,nf=%b%b want %b%b", bus.zf, bus.nf,
                               exp == 16'd0, exp[15]);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL idle_status: done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.result !== exp || bus.alu_opc !== opc || bus.alu_c !== cin) begin
            errors++; $display("FAIL idle_hold: result=%h opc=%0d c=%b want %h %0d %b",
                               bus.result, bus.alu_opc, bus.alu_c, exp, opc, cin);
        end
        if (we) ref_rf[dst] = exp;
    endtask

    // Reads register r through the ALU (r & r) and compares with a fixed value.
    task automatic check_reg(input logic [1:0] r, input logic [15:0] want);
        issue(3'd4, 2'd0, r, r, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        checks++;
        if (bus.result !== want) begin
            errors++; $display("FAIL reg_R%0d: got %h want %h", r, bus.result, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.ld_en = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 16'hAAAA;
        bus.instr = 12'hFFF;
        tick(); tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'd0 ||
            bus.zf !== 1'b0 || bus.nf !== 1'b0 || bus.alu_a !== 16'd0 ||
            bus.alu_b !== 16'd0 || bus.alu_c !== 1'b0 || bus.alu_opc !== 3'd0) begin
            errors++; $display("FAIL reset_outputs: busy=%b done=%b result=%h a=%h b=%h opc=%0d",
                               bus.busy, bus.done, bus.result, bus.alu_a, bus.alu_b, bus.alu_opc);
        end
        bus.start = 1'b0; bus.ld_en = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b want 0", bus.busy);
        end
        for (int i = 0; i < 4; i++) ref_rf[i] = 16'd0;
        check_reg(2'd1, 16'd0);
    endtask

    task automatic test_preload(input logic [1:0] a, input logic [15:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        tick();
        bus.ld_en = 1'b0;
        ref_rf[a] = d;
    endtask

    task automatic test_directed();
        test_preload(2'd0, 16'h0005);
        test_preload(2'd1, 16'h0003);
        issue(3'd2, 2'd2, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
        checks++;
        if (bus.result !== 16'h0009 || bus.zf !== 1'b0 || bus.nf !== 1'b0) begin
            errors++; $display("FAIL add_cin: got %h zf=%b nf=%b want 0009 0 0",
                               bus.result, bus.zf, bus.nf);
        end
        check_reg(2'd2, 16'h0009);
        issue(3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        checks++;
        if (bus.result !== 16'hFFFB || bus.nf !== 1'b1) begin
            errors++; $display("FAIL negate: got %h nf=%b want FFFB 1", bus.result, bus.nf);
        end
        check_reg(2'd3, 16'hFFFB);
        issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        checks++;
        if (bus.result !== 16'h0000 || bus.zf !== 1'b1) begin
            errors++; $display("FAIL zero_nowe: got %h zf=%b want 0000 1", bus.result, bus.zf);
        end
        check_reg(2'd1, 16'h0003);
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        bus.instr = {3'd2, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
        bus.start = 1'b1;
        tick();
        dones += int'(bus.done);
        tick();
        dones += int'(bus.done);
        bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 16'hBEEF;
        tick();
        dones += int'(bus.done);
        bus.ld_en = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dones += int'(bus.done);
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL busy_start_ignored: done pulses=%0d want 1", dones);
        end
        checks++;
        if (bus.result !== 16'h0008 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL busy_result: got %h busy=%b want 0008 0", bus.result, bus.busy);
        end
        check_reg(2'd0, 16'h0005);
    endtask

    task automatic test_load_start();
        issue(3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 16'h1234);
        checks++;
        if (bus.result !== 16'h1235) begin
            errors++; $display("FAIL load_start: got %h want 1235", bus.result);
        end
        // dst equal to a source: operands must be the pre-write values.
        issue(3'd2, 2'd2, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        check_reg(2'd2, 16'h246A);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) test_preload(2'($urandom), 16'($urandom));
            issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
        end
        for (int r = 0; r < 4; r++) check_reg(2'(r), ref_rf[r]);
    endtask

    task automatic test_reset_in_wb();
        test_preload(2'd0, 16'h0101);
        test_preload(2'd1, 16'h0202);
        bus.instr = {3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL rst_wb_reach: done=%b want 1", bus.done);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'd0 ||
            bus.zf !== 1'b0 || bus.nf !== 1'b0 || bus.alu_a !== 16'd0 ||
            bus.alu_b !== 16'd0 || bus.alu_c !== 1'b0 || bus.alu_opc !== 3'd0) begin
            errors++; $display("FAIL rst_wb_outputs: busy=%b done=%b result=%h a=%h b=%h",
                               bus.busy, bus.done, bus.result, bus.alu_a, bus.alu_b);
        end
        for (int i = 0; i < 4; i++) ref_rf[i] = 16'd0;
        for (int r = 0; r < 4; r++) check_reg(2'(r), 16'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.instr = '0; bus.ld_en = 1'b0;
        bus.ld_addr = '0; bus.ld_data = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_load_start();
        test_random();
        test_reset_in_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, datapath width; SHALL match the ALU operand width.
REQ-002 Parameter: NREG, 4, number of general registers; SHALL be a power of two.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request to execute instr; sampled only in IDLE.
REQ-006 instr  in  12  [11:9] opc, [8:7] dst, [6:5] srcA, [4:3] srcB, [2] cin, [1] we, [0] reserved.
REQ-007 ld_en  in  1  register preload strobe; honoured only in IDLE.
REQ-008 ld_addr  in  2  preload register index.
REQ-009 ld_data  in  WIDTH  preload value.
REQ-010 alu_a, alu_b  out  WIDTH  operands driven to the ALU inA/inB.
REQ-011 alu_c  out  1  carry-in driven to the ALU inC.
REQ-012 alu_opc  out  3  opcode driven to the ALU opc.
REQ-013 alu_w  in  WIDTH  ALU result outW.
REQ-014 alu_zer, alu_neg  in  1  ALU zero and negative flags.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 result  out  WIDTH  captured ALU result.
REQ-018 zf, nf  out  1  captured zero and negative flags.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, EXEC and WB, with the fixed cycle IDLE->FETCH->EXEC->WB->IDLE.
REQ-020 IDLE->FETCH SHALL occur on an edge where start=1, and instr SHALL be latched on that edge.
REQ-021 On the FETCH->EXEC edge, regfile[srcA] and regfile[srcB] SHALL be latched into the operand registers that drive alu_a and alu_b.
REQ-022 alu_opc and alu_c SHALL be driven from the latched instr fields, registered, and SHALL hold their values while in IDLE.
REQ-023 On the EXEC->WB edge, alu_w, alu_zer and alu_neg SHALL be captured into result, zf and nf.
REQ-024 done SHALL be high for exactly the one cycle spent in WB.
REQ-025 result, zf and nf SHALL be valid when done is high and SHALL hold until the next EXEC->WB edge.
REQ-026 On the WB->IDLE edge, regfile[dst] SHALL be written with result if we=1; if we=0 the regfile SHALL be unchanged.
REQ-027 If start is sampled at edge E0, done SHALL be high between E2 and E3, and the block SHALL be back in IDLE at E3.
REQ-028 start while busy SHALL be ignored, not queued; a new start SHALL be accepted in the first IDLE cycle after WB.
REQ-029 ld_en while busy SHALL be ignored.
REQ-030 ld_en in IDLE SHALL write ld_data to regfile[ld_addr] at that edge.
REQ-031 ld_en and start in the same IDLE cycle SHALL both take effect, and FETCH SHALL read the newly loaded value.
REQ-032 dst equal to srcA or srcB SHALL be legal; the operands SHALL be the pre-write values.
REQ-033 No arithmetic SHALL be performed in this block; result SHALL be alu_w bit-exact.

Reset
REQ-034 rst_n=0 at an edge SHALL force: state IDLE, busy=0, done=0, result=0, zf=0, nf=0, alu_a=0, alu_b=0, alu_c=0, alu_opc=0, and all registers to 0.
REQ-035 Reset in any state, including WB, SHALL suppress the pending write-back.
REQ-036 Reset SHALL take priority over start and ld_en.

Structure
REQ-037 A shared package SHALL hold the state encoding, the instr field bit positions and the WIDTH/NREG defaults.
REQ-038 The regfile SHALL be one sub-module, alu_regfile, with two combinational read ports and one synchronous write port; the write-port mux between load and write-back SHALL live in alu_issue_ctrl.

Verification
REQ-039 Preload R0=0x0005, R1=0x0003; opc=2, srcA=0, srcB=1, dst=2, cin=1, we=1 -> done 3 edges after start, result=0x0009, zf=0, nf=0, R2=0x0009.
REQ-040 R0=0x0005; opc=0, srcA=0, dst=3, we=1 -> result=0xFFFB, nf=1, R3=0xFFFB.
REQ-041 opc=7, dst=1, we=0 -> result=0x0000, zf=1, R1 unchanged at 0x0003.
REQ-042 start pulsed in FETCH, EXEC and WB, and ld_en in EXEC -> exactly one done pulse and the regfile unchanged by the load.
REQ-043 Same-cycle ld_en (ld_addr=0, ld_data=0x1234) and start with srcA=0, opc=1 -> result=0x1235.
REQ-044 rst_n=0 for one edge while in WB -> next cycle IDLE, busy=0, done=0, all outputs and registers 0, no write-back.
